// File: rtl/fft_pkg.sv
// Shared constants, state encoding and index-word helpers for the
// 16-point radix-4 FFT sequencer.
package fft_pkg;

  localparam int N      = 16;
  localparam int LANES  = 4;
  localparam int IDX_W  = 4;
  localparam int ROT_W  = 3;
  localparam int WORD_W = LANES * IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_S1_ISSUE = 3'd1,
    ST_S1_DRAIN = 3'd2,
    ST_S2_ISSUE = 3'd3,
    ST_S2_DRAIN = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Stage 1 group g reads samples g, g+4, g+8, g+12 (lane k = g + 4k).
  function automatic logic [WORD_W-1:0] s1_idx(input logic [1:0] g);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      w[k*IDX_W +: IDX_W] = {2'(k), g};
    end
    return w;
  endfunction

  // Stage 2 group g reads four consecutive samples 4g .. 4g+3 (lane k = 4g + k).
  function automatic logic [WORD_W-1:0] s2_idx(input logic [1:0] g);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      w[k*IDX_W +: IDX_W] = {g, 2'(k)};
    end
    return w;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Valid-tagged shift register carrying {indices, rotation} from issue to the
// butterfly input tap and the write-back tap. Invalid slots carry zeros so the
// taps can drive outputs directly.
module fft_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 19,
  parameter int TAP_A = 1,
  parameter int TAP_B = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         a_valid,
  output logic [W-1:0] a_data,
  output logic         b_valid,
  output logic [W-1:0] b_data,
  output logic         empty,
  output logic         empty_next
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_d[gi] = push;
        assign data_d[gi]  = push ? din : '0;
      end else begin : g_body
        assign valid_d[gi] = valid_q[gi-1];
        assign data_d[gi]  = data_q[gi-1];
      end
    end
  endgenerate

  // Advance every slot by one each cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  // A tap at latency T is the slot written T edges after the push.
  assign a_valid = valid_q[TAP_A-1];
  assign a_data  = data_q[TAP_A-1];
  assign b_valid = valid_q[TAP_B-1];
  assign b_data  = data_q[TAP_B-1];

  assign empty      = ~|valid_q;
  // Line will be empty after this edge: nothing entering and only the final
  // slot (about to fall off) may still be occupied.
  assign empty_next = ~push & ~|valid_q[DEPTH-2:0];

endmodule

// File: rtl/fft16_sched.sv
// Sequencer for the 16-point radix-4 FFT: issues two stages of four grouped
// reads, tags each with a rotation code, and replays the indices as write-back
// addresses once the read and butterfly latencies have elapsed.
module fft16_sched
  import fft_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [WORD_W-1:0] rd_idx,
  output logic [ROT_W-1:0]  bf_rotation,
  output logic              bf_valid,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_idx
);

  localparam int L  = RD_LAT + BF_LAT;
  localparam int PW = WORD_W + ROT_W;

  state_t            state_q, state_d;
  logic [1:0]        g_q, g_d;
  logic              issue;
  logic [WORD_W-1:0] issue_idx;
  logic [ROT_W-1:0]  issue_rot;

  logic              a_valid, b_valid;
  logic [PW-1:0]     a_data, b_data;
  logic              dl_empty, dl_empty_next;
  logic              unused_bits;

  // Next-state and issue decode; the drain states leave once the last
  // in-flight write is retiring so the next read lands one cycle after it.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    issue     = 1'b0;
    issue_idx = '0;
    issue_rot = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_S1_ISSUE;
          g_d     = 2'd0;
        end
      end
      ST_S1_ISSUE: begin
        issue     = 1'b1;
        issue_idx = s1_idx(g_q);
        issue_rot = {1'b0, g_q};
        g_d       = g_q + 2'd1;
        if (g_q == 2'd3) state_d = ST_S1_DRAIN;
      end
      ST_S1_DRAIN: begin
        if (dl_empty || dl_empty_next) state_d = ST_S2_ISSUE;
      end
      ST_S2_ISSUE: begin
        issue     = 1'b1;
        issue_idx = s2_idx(g_q);
        issue_rot = {1'b1, g_q};
        g_d       = g_q + 2'd1;
        if (g_q == 2'd3) state_d = ST_S2_DRAIN;
      end
      ST_S2_DRAIN: begin
        if (dl_empty || dl_empty_next) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and group counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
    end
  end

  fft_delay_line #(
    .DEPTH (L),
    .W     (PW),
    .TAP_A (RD_LAT),
    .TAP_B (L)
  ) u_dl (
    .clk        (clk),
    .rst        (rst),
    .push       (issue),
    .din        ({issue_idx, issue_rot}),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .empty      (dl_empty),
    .empty_next (dl_empty_next)
  );

  assign busy        = (state_q == ST_S1_ISSUE) || (state_q == ST_S1_DRAIN) ||
                       (state_q == ST_S2_ISSUE) || (state_q == ST_S2_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign rd_en       = issue;
  assign rd_idx      = issue_idx;
  assign bf_valid    = a_valid;
  assign bf_rotation = a_data[ROT_W-1:0];
  assign wr_en       = b_valid;
  assign wr_idx      = b_data[PW-1:ROT_W];

  // The butterfly tap only needs the rotation and the write tap only the indices.
  assign unused_bits = ^{a_data[PW-1:ROT_W], b_data[ROT_W-1:0]};

endmodule

// File: tb/tb_fft16_sched.sv
// Bench for fft16_sched: four instances with different latency pairs share
// one stimulus stream; a timeline model predicts every output every cycle.
module tb_fft16_sched;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic        o_busy [NI];
  logic        o_done [NI];
  logic        o_rd_en [NI];
  logic [15:0] o_rd_idx [NI];
  logic [2:0]  o_bf_rot [NI];
  logic        o_bf_valid [NI];
  logic        o_wr_en [NI];
  logic [15:0] o_wr_idx [NI];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int t0 [NI];

  logic [15:0] s1lit [4] = '{16'hC840, 16'hD951, 16'hEA62, 16'hFB73};
  logic [15:0] s2lit [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

  always #5 clk = ~clk;

  function automatic int lat_rd(int i);
    return (i >= 2) ? 3 : 1;
  endfunction

  function automatic int lat_bf(int i);
    return (i % 2 == 1) ? 4 : 1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      fft16_sched #(
        .RD_LAT ((gi >= 2) ? 3 : 1),
        .BF_LAT ((gi % 2 == 1) ? 4 : 1)
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (o_busy[gi]),
        .done        (o_done[gi]),
        .rd_en       (o_rd_en[gi]),
        .rd_idx      (o_rd_idx[gi]),
        .bf_rotation (o_bf_rot[gi]),
        .bf_valid    (o_bf_valid[gi]),
        .wr_en       (o_wr_en[gi]),
        .wr_idx      (o_wr_idx[gi])
      );
    end
  endgenerate

  // Issue schedule relative to the accepted start: {valid, idx word, rotation}.
  function automatic logic [19:0] issue_at(int k, int L);
    int g;
    int st;
    logic [15:0] idx;
    idx = '0;
    if (k >= 1 && k <= 4) begin
      st = 0;
      g = k - 1;
    end else if (k >= 5 + L && k <= 8 + L) begin
      st = 1;
      g = k - 5 - L;
    end else begin
      return 20'd0;
    end
    for (int j = 0; j < 4; j++)
      idx[4*j +: 4] = (st == 0) ? 4'(g + 4*j) : 4'(4*g + j);
    return {1'b1, idx, 3'(st*4 + g)};
  endfunction

  // Full expected output vector at offset k from the accepted start.
  function automatic logic [39:0] expect_out(int k, int R, int L);
    logic [19:0] a, b, w;
    logic bz, dn;
    a = issue_at(k, L);
    b = issue_at(k - R, L);
    w = issue_at(k - L, L);
    bz = (k >= 1 && k <= 8 + 2*L);
    dn = (k == 9 + 2*L);
    return {bz, dn, a[19], a[18:3], b[19], b[2:0], w[19], w[18:3]};
  endfunction

  // Model: track, per instance, the cycle in which a start was accepted.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) t0[i] = -1;
      else if (start && (t0[i] < 0 || cyc - t0[i] >= 10 + 2*(lat_rd(i) + lat_bf(i))))
        t0[i] = cyc;
    end
    if (rst) chk_en = 1'b1;
    cyc = cyc + 1;
  end

  logic [16:0] rd_hist [NI][32];
  int hist [NI][16];
  int rd_cnt [NI];
  int wr_cnt [NI];

  // Compare process: every cycle, every instance.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        int R, L, k;
        logic [39:0] exp_v, act_v;
        R = lat_rd(i);
        L = R + lat_bf(i);
        k = (t0[i] < 0) ? -1000 : cyc - t0[i];
        exp_v = expect_out(k, R, L);
        act_v = {o_busy[i], o_done[i], o_rd_en[i], o_rd_idx[i], o_bf_valid[i],
                 o_bf_rot[i], o_wr_en[i], o_wr_idx[i]};
        n_chk++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs inst=%0d cyc=%0d k=%0d got=%h want=%h", i, cyc, k, act_v, exp_v);
        end

        // Literal pins for the default-latency instance.
        if (i == 0) begin
          if (k >= 1 && k <= 4) begin
            n_chk++;
            if (o_rd_idx[i] !== s1lit[k-1]) begin
              n_fail++;
              $display("FAIL pin_s1_rd k=%0d got=%h want=%h", k, o_rd_idx[i], s1lit[k-1]);
            end
          end
          if (k >= 7 && k <= 10) begin
            n_chk++;
            if (o_rd_idx[i] !== s2lit[k-7]) begin
              n_fail++;
              $display("FAIL pin_s2_rd k=%0d got=%h want=%h", k, o_rd_idx[i], s2lit[k-7]);
            end
          end
          if ((k >= 2 && k <= 5) || (k >= 8 && k <= 11)) begin
            n_chk++;
            if ({o_bf_valid[i], o_bf_rot[i]} !== {1'b1, 3'((k <= 5) ? k - 2 : k - 4)}) begin
              n_fail++;
              $display("FAIL pin_rot k=%0d got=%b/%0d", k, o_bf_valid[i], o_bf_rot[i]);
            end
          end
          if (k == 13 || k == 12) begin
            n_chk++;
            if (o_done[i] !== (k == 13)) begin
              n_fail++;
              $display("FAIL pin_done k=%0d got=%b want=%b", k, o_done[i], (k == 13));
            end
          end
        end

        // Scoreboard: per-transform bookkeeping restarts on the first issue cycle.
        if (k == 1) begin
          rd_cnt[i] = 0;
          wr_cnt[i] = 0;
          for (int v = 0; v < 16; v++) hist[i][v] = 0;
        end
        if (o_wr_en[i] === 1'b1) begin
          logic [16:0] h;
          h = rd_hist[i][(cyc - L) & 31];
          n_chk++;
          if (h !== {1'b1, o_wr_idx[i]}) begin
            n_fail++;
            $display("FAIL wr_vs_rd inst=%0d cyc=%0d got=%h want=%h", i, cyc, {1'b1, o_wr_idx[i]}, h);
          end
          for (int j = 0; j < 4; j++) hist[i][o_wr_idx[i][4*j +: 4]]++;
          wr_cnt[i]++;
        end
        if (o_rd_en[i] === 1'b1) begin
          if (rd_cnt[i] >= 4) begin
            n_chk++;
            if (wr_cnt[i] < 4) begin
              n_fail++;
              $display("FAIL hazard inst=%0d cyc=%0d stage1_writes=%0d want=4", i, cyc, wr_cnt[i]);
            end
          end
          rd_cnt[i]++;
        end
        rd_hist[i][cyc & 31] = {o_rd_en[i], o_rd_idx[i]};
        if (o_done[i] === 1'b1) begin
          for (int v = 0; v < 16; v++) begin
            n_chk++;
            if (hist[i][v] != 2) begin
              n_fail++;
              $display("FAIL multiset inst=%0d idx=%0d got=%0d want=2", i, v, hist[i][v]);
            end
          end
        end
      end
    end
  end

  // Drive inputs for n cycles, changing them just after a rising edge.
  task automatic drive(input logic s, input logic r, input int n);
    start = s;
    rst = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      t0[i] = -1;
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
      for (int v = 0; v < 16; v++) hist[i][v] = 0;
      for (int h = 0; h < 32; h++) rd_hist[i][h] = '0;
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 3);
    // Single transform, long idle so every latency pair completes.
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 30);
    // start held high: back-to-back transforms, presses while busy ignored.
    drive(1'b1, 1'b0, 60);
    drive(1'b0, 1'b0, 30);
    // Reset in the middle of stage 1 drain, then a clean restart.
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 5);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 30);
    // start and rst together: reset wins.
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 5);
    // Random start pulses with occasional resets.
    for (int c = 0; c < 3000; c++)
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0), 1);
    drive(1'b0, 1'b0, 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
